video_frame_monitor: RTL and testbench



---
 rtl/video_frame_monitor.sv | 180 ++++++++++++++++++
 tb/tb_video_frame_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_monitor.sv
// Passive per-frame measurement of a pixel stream: active width/height, line-width consistency
// and a CRC-16-CCITT signature of RGB data, latched once per frame for debug and self-test.
module video_frame_monitor #(
  parameter int COORDSPC = 16,
  parameter int COLSPC   = 10
) (
  input  logic                video_clk_pix,
  input  logic                video_rst_n,
  input  logic                video_enable,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic [COLSPC-1:0]   red,
  input  logic [COLSPC-1:0]   green,
  input  logic [COLSPC-1:0]   blue,
  output logic [COORDSPC-1:0] line_width,
  output logic [COORDSPC-1:0] frame_height,
  output logic [15:0]         frame_crc,
  output logic [15:0]         frame_count,
  output logic                width_err,
  output logic                stable,
  output logic                meas_valid,
  output logic                dbg_state
);

  localparam int PIXW = 3 * COLSPC;
  localparam logic [COORDSPC-1:0] CMAX = {COORDSPC{1'b1}};
  localparam logic [COORDSPC-1:0] CONE = {{(COORDSPC-1){1'b0}}, 1'b1};

  typedef enum logic {SYNC_WAIT = 1'b0, MEASURE = 1'b1} state_t;

  // Shifts one whole pixel word into the CRC, MSB first, in a single cycle.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [PIXW-1:0] pix);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = PIXW - 1; i >= 0; i--) begin
      fb = c[15] ^ pix[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [COORDSPC-1:0] cur_w_q, cur_w_d;
  logic [COORDSPC-1:0] ref_w_q, ref_w_d;
  logic                ref_seen_q, ref_seen_d;
  logic [COORDSPC-1:0] height_acc_q, height_acc_d;
  logic                err_acc_q, err_acc_d;
  logic [15:0]         crc_acc_q, crc_acc_d;
  logic [COORDSPC-1:0] line_width_q, line_width_d;
  logic [COORDSPC-1:0] frame_height_q, frame_height_d;
  logic [15:0]         frame_crc_q, frame_crc_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                width_err_q, width_err_d;
  logic                stable_q, stable_d;
  logic                meas_valid_q, meas_valid_d;

  logic [PIXW-1:0]     pix_w;
  logic                close_act;
  logic [COORDSPC-1:0] height_close, ref_close;
  logic                seen_close, err_close;
  logic [15:0]         crc_base, crc_next;

  // meas_valid is a bare one-cycle strobe (no ready): the sink must sample the
  // result outputs in the cycle it is high; they then hold until the next frame.
  always_comb begin
    state_d        = state_q;
    cur_w_d        = cur_w_q;
    ref_w_d        = ref_w_q;
    ref_seen_d     = ref_seen_q;
    height_acc_d   = height_acc_q;
    err_acc_d      = err_acc_q;
    crc_acc_d      = crc_acc_q;
    line_width_d   = line_width_q;
    frame_height_d = frame_height_q;
    frame_crc_d    = frame_crc_q;
    frame_count_d  = frame_count_q;
    width_err_d    = width_err_q;
    stable_d       = stable_q;
    meas_valid_d   = 1'b0;

    // Values as they stand once the line in progress is closed.
    pix_w        = {red, green, blue};
    close_act    = (cur_w_q != '0);
    height_close = (close_act && height_acc_q != CMAX) ? height_acc_q + CONE : height_acc_q;
    ref_close    = (close_act && !ref_seen_q) ? cur_w_q : ref_w_q;
    seen_close   = ref_seen_q | close_act;
    err_close    = err_acc_q | (close_act && ref_seen_q && (cur_w_q != ref_w_q));
    crc_base     = frame_start ? 16'hFFFF : crc_acc_q;
    crc_next     = crc_step(crc_base, pix_w);

    case (state_q)
      SYNC_WAIT: begin
        if (frame_start) begin
          state_d      = MEASURE;
          cur_w_d      = {{(COORDSPC-1){1'b0}}, video_enable};
          ref_w_d      = '0;
          ref_seen_d   = 1'b0;
          height_acc_d = '0;
          err_acc_d    = 1'b0;
          crc_acc_d    = video_enable ? crc_next : 16'hFFFF;
        end
      end
      MEASURE: begin
        if (frame_start) begin
          line_width_d   = ref_close;
          frame_height_d = height_close;
          frame_crc_d    = crc_acc_q;
          width_err_d    = err_close;
          frame_count_d  = frame_count_q + 16'd1;
          stable_d       = (frame_count_q != 16'd0) && (crc_acc_q == frame_crc_q) &&
                           (ref_close == line_width_q) && (height_close == frame_height_q);
          meas_valid_d   = 1'b1;
          cur_w_d        = {{(COORDSPC-1){1'b0}}, video_enable};
          ref_w_d        = '0;
          ref_seen_d     = 1'b0;
          height_acc_d   = '0;
          err_acc_d      = 1'b0;
          crc_acc_d      = video_enable ? crc_next : 16'hFFFF;
        end else begin
          if (video_enable) crc_acc_d = crc_next;
          if (line_start) begin
            height_acc_d = height_close;
            ref_w_d      = ref_close;
            ref_seen_d   = seen_close;
            err_acc_d    = err_close;
            cur_w_d      = {{(COORDSPC-1){1'b0}}, video_enable};
          end else if (video_enable && cur_w_q != CMAX) begin
            cur_w_d = cur_w_q + CONE;
          end
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      state_q        <= SYNC_WAIT;
      cur_w_q        <= '0;
      ref_w_q        <= '0;
      ref_seen_q     <= 1'b0;
      height_acc_q   <= '0;
      err_acc_q      <= 1'b0;
      crc_acc_q      <= 16'hFFFF;
      line_width_q   <= '0;
      frame_height_q <= '0;
      frame_crc_q    <= 16'hFFFF;
      frame_count_q  <= 16'd0;
      width_err_q    <= 1'b0;
      stable_q       <= 1'b0;
      meas_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_w_q        <= cur_w_d;
      ref_w_q        <= ref_w_d;
      ref_seen_q     <= ref_seen_d;
      height_acc_q   <= height_acc_d;
      err_acc_q      <= err_acc_d;
      crc_acc_q      <= crc_acc_d;
      line_width_q   <= line_width_d;
      frame_height_q <= frame_height_d;
      frame_crc_q    <= frame_crc_d;
      frame_count_q  <= frame_count_d;
      width_err_q    <= width_err_d;
      stable_q       <= stable_d;
      meas_valid_q   <= meas_valid_d;
    end
  end

  assign line_width   = line_width_q;
  assign frame_height = frame_height_q;
  assign frame_crc    = frame_crc_q;
  assign frame_count  = frame_count_q;
  assign width_err    = width_err_q;
  assign stable       = stable_q;
  assign meas_valid   = meas_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_video_frame_monitor.sv
// Bench for video_frame_monitor: drives whole frames cycle by cycle and scores each
// latched result against a frame-level model built from the recorded lines and pixels.
module tb_video_frame_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, fs = 1'b0, ls = 1'b0;
  logic [9:0]  r = '0, g = '0, b = '0;
  logic [15:0] line_width, frame_height, frame_crc, frame_count;
  logic        width_err, stable, meas_valid, dbg_state;

  always #5 clk = ~clk;

  video_frame_monitor #(.COORDSPC(16), .COLSPC(10)) dut (
    .video_clk_pix(clk), .video_rst_n(rst_n), .video_enable(en),
    .frame_start(fs), .line_start(ls), .red(r), .green(g), .blue(b),
    .line_width(line_width), .frame_height(frame_height), .frame_crc(frame_crc),
    .frame_count(frame_count), .width_err(width_err), .stable(stable),
    .meas_valid(meas_valid), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: raw record of the current frame, plus the expected latched results.
  logic [29:0] pix_q[$];
  int          lw_q[$];
  int          cur_len;
  bit          have_frame;
  logic [15:0] exp_w, exp_h, exp_crc, exp_count;
  bit          exp_err, exp_stable, exp_valid;
  logic [66:0] got, want;

  int          plan_w[$];
  bit          rnd_pix;
  logic [29:0] pix_val;

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [29:0] p);
    logic [15:0] x;
    x = c;
    for (int i = 29; i >= 0; i--) begin
      if (x[15] ^ p[i]) x = (x << 1) ^ 16'h1021;
      else              x = x << 1;
    end
    return x;
  endfunction

  function automatic void model_reset();
    have_frame = 0; pix_q.delete(); lw_q.delete(); cur_len = 0;
    exp_w = 0; exp_h = 0; exp_crc = 16'hFFFF; exp_count = 0;
    exp_err = 0; exp_stable = 0; exp_valid = 0;
  endfunction

  function automatic void model_close();
    int w, h;
    bit e;
    logic [15:0] c;
    exp_valid = have_frame;
    if (have_frame) begin
      w = 0; h = 0; e = 0;
      foreach (lw_q[i]) if (lw_q[i] != 0) begin
        h++;
        if (w == 0) w = lw_q[i];
        else if (lw_q[i] != w) e = 1;
      end
      c = 16'hFFFF;
      foreach (pix_q[i]) c = crc_word(c, pix_q[i]);
      exp_stable = (exp_count != 0) && (c == exp_crc) && (w == int'(exp_w)) && (h == int'(exp_h));
      exp_w = w[15:0]; exp_h = h[15:0]; exp_crc = c; exp_err = e;
      exp_count = exp_count + 16'd1;
    end
    have_frame = 1; pix_q.delete(); lw_q.delete();
  endfunction

  // One pixel-clock cycle of stimulus; inactive cycles carry random colour garbage.
  task automatic cycle(input bit f, input bit l, input bit e);
    logic [29:0] p;
    p = (e && !rnd_pix) ? pix_val : 30'($urandom);
    fs = f; ls = l; en = e; {r, g, b} = p;
    if (f || l) begin lw_q.push_back(cur_len); cur_len = 0; end
    if (f) model_close();
    if (e) begin cur_len++; pix_q.push_back(p); end
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input bit e0);
    cycle(1, 1, e0);
  endtask

  task automatic frame_body();
    cycle(0, 0, 0);
    for (int i = 0; i < plan_w.size(); i++) begin
      if (i > 0) cycle(0, 1, 0);
      cycle(0, 0, 0);
      repeat (plan_w[i]) cycle(0, 0, 1);
      cycle(0, 0, 0);
    end
    cycle(0, 0, 0);
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++; $display("FAIL body_meas_valid got=%0b exp=0", meas_valid);
    end
  endtask

  // Fields in got/want: {width, height, crc, err, stable, count, meas_valid}
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    checks++;
    if (got !== {16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", got, {16'h0, 16'h0, 16'hFFFF, 3'b0, 16'h0, 1'b0});
    end
    checks++;
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    rnd_pix = 0; pix_val = '0; plan_w = '{8, 8, 8, 8};
    cycle(0, 1, 1);  // partial frame before sync, must be ignored
    start_frame(0);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL basic_sync got=%h exp=%h", got, want); end
    checks++;
    if (dbg_state !== 1'b1) begin errors++; $display("FAIL basic_state got=%0b exp=1", dbg_state); end
    for (int f = 1; f <= 3; f++) begin
      frame_body();
      start_frame(0);
      got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
      want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
      checks++;
      if (got !== want) begin errors++; $display("FAIL basic_f%0d got=%h exp=%h", f, got, want); end
      checks++;
      if ({line_width, frame_height, width_err, stable, frame_count} !==
          {16'd8, 16'd4, 1'b0, (f > 1), 16'(f)}) begin
        errors++;
        $display("FAIL basic_plan_f%0d got w=%0d h=%0d err=%0b st=%0b cnt=%0d exp w=8 h=4 err=0 st=%0b cnt=%0d",
                 f, line_width, frame_height, width_err, stable, frame_count, (f > 1), f);
      end
    end
  endtask

  task automatic test_empty_frame();
    plan_w = '{};
    frame_body();
    start_frame(0);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL empty got=%h exp=%h", got, want); end
    checks++;
    if ({frame_crc, line_width, frame_height, width_err} !== {16'hFFFF, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL empty_plan got crc=%h w=%0d h=%0d err=%0b exp crc=ffff w=0 h=0 err=0",
               frame_crc, line_width, frame_height, width_err);
    end
  endtask

  task automatic test_single_pixel();
    rnd_pix = 0; pix_val = {10'h3FF, 10'h000, 10'h155}; plan_w = '{1};
    for (int k = 0; k < 3; k++) begin
      if (k == 2) pix_val = pix_val ^ 30'h0000_0080;
      frame_body();
      start_frame(0);
      got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
      want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
      checks++;
      if (got !== want) begin errors++; $display("FAIL single_px_%0d got=%h exp=%h", k, got, want); end
      checks++;
      if (stable !== (k == 1)) begin
        errors++; $display("FAIL single_px_stable_%0d got=%0b exp=%0b", k, stable, (k == 1));
      end
    end
  endtask

  task automatic test_width_err();
    rnd_pix = 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) plan_w = '{8, 8, 7, 8};
      else        plan_w = '{8, 8, 8, 8};
      frame_body();
      start_frame(0);
      got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
      want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
      checks++;
      if (got !== want) begin errors++; $display("FAIL width_err_%0d got=%h exp=%h", k, got, want); end
      checks++;
      if ({line_width, frame_height, width_err} !== {16'd8, 16'd4, (k == 0)}) begin
        errors++;
        $display("FAIL width_err_plan_%0d got w=%0d h=%0d err=%0b exp w=8 h=4 err=%0b",
                 k, line_width, frame_height, width_err, (k == 0));
      end
    end
  endtask

  task automatic test_coincident();
    rnd_pix = 1; plan_w = '{5, 5};
    frame_body();
    start_frame(1);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL coincident_close got=%h exp=%h", got, want); end
    checks++;
    if (frame_height !== 16'd2) begin errors++; $display("FAIL coincident_height got=%0d exp=2", frame_height); end
    frame_body();
    start_frame(0);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL coincident_next got=%h exp=%h", got, want); end
    checks++;
    if ({line_width, width_err} !== {16'd6, 1'b1}) begin
      errors++; $display("FAIL coincident_width got w=%0d err=%0b exp w=6 err=1", line_width, width_err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      rnd_pix = 1'($urandom_range(0, 1));
      pix_val = 30'($urandom);
      plan_w.delete();
      repeat ($urandom_range(0, 5)) plan_w.push_back($urandom_range(0, 12));
      for (int rep = 0; rep < 2; rep++) begin
        frame_body();
        start_frame(1'($urandom_range(0, 1)));
        got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
        want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
        checks++;
        if (got !== want) begin errors++; $display("FAIL random_%0d_%0d got=%h exp=%h", it, rep, got, want); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rnd_pix = 1;
    cycle(0, 1, 0);
    repeat (4) cycle(0, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    checks++;
    if (got !== {16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_async got=%h exp=%h", got, {16'h0, 16'h0, 16'hFFFF, 3'b0, 16'h0, 1'b0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    start_frame(0);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL mid_reset_sync got=%h exp=%h", got, want); end
    plan_w = '{3, 3};
    frame_body();
    start_frame(0);
    got = {line_width, frame_height, frame_crc, width_err, stable, frame_count, meas_valid};
    want = {exp_w, exp_h, exp_crc, exp_err, exp_stable, exp_count, exp_valid};
    checks++;
    if (got !== want) begin errors++; $display("FAIL mid_reset_first got=%h exp=%h", got, want); end
  endtask

  initial begin
    model_reset();
    rnd_pix = 0; pix_val = '0;
    test_reset();
    test_basic();
    test_empty_frame();
    test_single_pixel();
    test_width_err();
    test_coincident();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
